trigger_delay_pulse_gen: RTL

//  Consumes the single-cycle edge pulse from the synchronising edge detector.

---
 rtl/trigger_delay_pkg.sv | 26 ++
 rtl/trigger_delay_pulse_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/trigger_delay_pkg.sv
// Package: trigger_delay_pkg
// Purpose: shared types and helpers for the trigger-delay stage.
//   state_t  - FSM state encoding of the delayed pulse generator
//   sat_inc  - saturating increment of a counter up to 32 bits wide
package trigger_delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    PULSE = 2'd3
  } state_t;

  // Widest counter the saturating helper supports.
  localparam int unsigned SAT_MAX_W = 32;

  // Returns value+1, holding at the all-ones value of a 'width'-bit counter.
  // Callers zero-extend their counter into the argument and truncate the result.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                   input int unsigned           width);
    logic [SAT_MAX_W-1:0] max_v;
    max_v = (width >= SAT_MAX_W) ? '1 : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? max_v : value + 32'd1;
  endfunction

endpackage

// File: rtl/trigger_delay_pulse_gen.sv
// Module: trigger_delay_pulse_gen
// Purpose: after an accepted edge pulse, waits a programmable number of clk
//   cycles, then drives a programmable-width output pulse. Single-shot or
//   continuous (auto re-arm) operation; counts fired and missed triggers.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   trig_in           - 1-cycle edge pulse from the edge detector
//   arm, disarm       - 1-cycle control strobes (disarm wins over everything)
//   continuous        - 1 = re-arm after each pulse, 0 = single shot
//   delay_cycles      - cycles from trig_in to trig_out rise (sampled at accept)
//   pulse_cycles      - trig_out high time, 0 treated as 1 (sampled at accept)
//   trig_out          - delayed trigger pulse (registered)
//   armed, busy       - status flags (registered)
//   fire_count        - pulses issued, saturating
//   miss_count        - triggers ignored while running, saturating
// CNT_W must not exceed 32 (width of the shared saturating helper).
module trigger_delay_pulse_gen
  import trigger_delay_pkg::*;
#(
  parameter int unsigned DELAY_W = 32,
  parameter int unsigned WIDTH_W = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trig_in,
  input  logic               arm,
  input  logic               disarm,
  input  logic               continuous,
  input  logic [DELAY_W-1:0] delay_cycles,
  input  logic [WIDTH_W-1:0] pulse_cycles,
  output logic               trig_out,
  output logic               armed,
  output logic               busy,
  output logic [CNT_W-1:0]   fire_count,
  output logic [CNT_W-1:0]   miss_count
);

  // One down-counter serves both the delay and the pulse-width phase.
  localparam int unsigned CW = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH_W-1:0] width_q;
  logic               cont_q;
  logic               trig_out_q;
  logic               armed_q;
  logic               busy_q;
  logic [CNT_W-1:0]   fire_q;
  logic [CNT_W-1:0]   miss_q;

  logic [WIDTH_W-1:0] width_eff;
  logic [CNT_W-1:0]   fire_d;
  logic [CNT_W-1:0]   miss_d;
  logic               cnt_last;

  assign width_eff = (pulse_cycles == '0) ? WIDTH_W'(1) : pulse_cycles;
  assign fire_d    = CNT_W'(sat_inc(SAT_MAX_W'(fire_q), CNT_W));
  assign miss_d    = CNT_W'(sat_inc(SAT_MAX_W'(miss_q), CNT_W));
  // The counter is loaded with N and the phase ends in the cycle it reads 1,
  // so a phase lasts exactly N cycles even for N = all-ones.
  assign cnt_last  = (cnt_q == CW'(1));

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      width_q    <= '0;
      cont_q     <= 1'b0;
      trig_out_q <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      fire_q     <= '0;
      miss_q     <= '0;
    end else if (disarm) begin
      state_q    <= IDLE;
      trig_out_q <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm) begin
            state_q <= ARMED;
            armed_q <= 1'b1;
          end
        end

        ARMED: begin
          if (trig_in) begin
            width_q <= width_eff;
            cont_q  <= continuous;
            busy_q  <= 1'b1;
            if (delay_cycles == '0) begin
              state_q    <= PULSE;
              cnt_q      <= CW'(width_eff);
              trig_out_q <= 1'b1;
              fire_q     <= fire_d;
            end else begin
              state_q <= DELAY;
              cnt_q   <= CW'(delay_cycles);
            end
          end
        end

        DELAY: begin
          if (trig_in) miss_q <= miss_d;
          if (cnt_last) begin
            state_q    <= PULSE;
            cnt_q      <= CW'(width_q);
            trig_out_q <= 1'b1;
            fire_q     <= fire_d;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        PULSE: begin
          if (trig_in) miss_q <= miss_d;
          if (cnt_last) begin
            trig_out_q <= 1'b0;
            busy_q     <= 1'b0;
            if (cont_q) begin
              state_q <= ARMED;
            end else begin
              state_q <= IDLE;
              armed_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign trig_out   = trig_out_q;
  assign armed      = armed_q;
  assign busy       = busy_q;
  assign fire_count = fire_q;
  assign miss_count = miss_q;

endmodule
